// File: rtl/mips_pkg.sv
// mips_pkg: shared types and helpers for the data-memory responder
package mips_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;
    localparam int WORD_BYTES = 4;
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction
endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: single-port word RAM, synchronous write with combinational read
module dmem_ram #(
    parameter int DEPTH = 64,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] mem [DEPTH];
    always_ff @(posedge clk)
        if (we) mem[addr] <= wdata;
    assign rdata = mem[addr];
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: wait-state data memory with stall, completion register and sticky errors
module dmem_responder
    import mips_pkg::*;
#(
    parameter int          DEPTH_WORDS = 64,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] DONE_ADDR   = 32'd84
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        memwrite,
    input  logic        memread,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] done_value,
    output logic        err
);
    localparam int AW = addr_width(DEPTH_WORDS);
    localparam int OFS = $clog2(WORD_BYTES);
    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);
    dmem_state_t state, state_n;
    logic [3:0]  cnt;
    logic [31:0] lat_adr, lat_data, cur_adr, cur_data, ram_q;
    logic        lat_wr, lat_both, cur_wr, cur_both, req, aligned, enter_resp, ram_we;
    assign req = memwrite | memread;
    // With one wait state the RESP entry edge is the request edge, so use live inputs in IDLE
    assign cur_adr    = (state == IDLE) ? dataadr : lat_adr;
    assign cur_data   = (state == IDLE) ? writedata : lat_data;
    assign cur_wr     = (state == IDLE) ? memwrite : lat_wr;
    assign cur_both   = (state == IDLE) ? (memwrite & memread) : lat_both;
    assign aligned    = (cur_adr[OFS-1:0] == '0);
    assign enter_resp = (state_n == RESP) && (state != RESP);
    assign ram_we     = reset_n & enter_resp & cur_wr & aligned;
    always_comb begin
        state_n = state;
        stall   = 1'b0;
        case (state)
            IDLE: if (req) begin
                stall   = 1'b1;
                state_n = (CNT_INIT != 4'd0) ? WAIT : RESP;
            end
            WAIT: begin
                stall   = 1'b1;
                state_n = (cnt == 4'd1) ? RESP : WAIT;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            readdata   <= 32'd0;
            done       <= 1'b0;
            done_value <= 32'd0;
            err        <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && req) begin
                cnt      <= CNT_INIT;
                lat_adr  <= dataadr;
                lat_data <= writedata;
                lat_wr   <= memwrite;
                lat_both <= memwrite & memread;
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (enter_resp) begin
                if (!cur_wr) readdata <= aligned ? ram_q : 32'd0;
                if (!aligned || cur_both) err <= 1'b1;
                if (cur_wr && aligned && cur_adr == DONE_ADDR) begin
                    done       <= 1'b1;
                    done_value <= cur_data;
                end
            end
        end
    end
    dmem_ram #(.DEPTH(DEPTH_WORDS), .AW(AW)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (cur_adr[OFS +: AW]),
        .wdata (cur_data),
        .rdata (ram_q)
    );
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: vector table, reset sequences and random traffic against a transaction-level model
module tb_dmem_responder;
    localparam int WC = 2;
    localparam int DW = 64;
    logic        clk = 1'b0, reset_n = 1'b0, memwrite = 1'b0, memread = 1'b0;
    logic [31:0] dataadr = '0, writedata = '0;
    logic [31:0] readdata, done_value;
    logic        stall, done, err;
    int vectors = 0, miscompares = 0;
    logic [31:0] mem_m [DW];
    logic [31:0] rd_m = '0, dv_m = '0;
    bit          done_m = 0, err_m = 0;

    typedef struct {
        bit          wr, rd;
        logic [31:0] adr, data, e_rd, e_dv;
        bit          e_done, e_err;
    } vec_t;
    vec_t tbl [13];

    dmem_responder #(.DEPTH_WORDS(DW), .WAIT_CYCLES(WC), .DONE_ADDR(32'd84)) dut (
        .clk(clk), .reset_n(reset_n), .memwrite(memwrite), .memread(memread),
        .dataadr(dataadr), .writedata(writedata), .readdata(readdata),
        .stall(stall), .done(done), .done_value(done_value), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Entered and left 1 time unit after a rising edge; checks are made in the response cycle
    task automatic access(input bit wr, input bit rd, input logic [31:0] adr, input logic [31:0] data,
                          input bit use_model, input logic [31:0] e_rd, input logic [31:0] e_dv,
                          input bit e_done, input bit e_err, input string tag);
        int n = 0;
        int i = int'((adr / 4) % DW);
        bit misal = (adr % 4) != 0;
        memwrite = wr; memread = rd; dataadr = adr; writedata = data;
        @(negedge clk);
        while (stall && n < 40) begin
            n++;
            @(negedge clk);
        end
        if (wr) begin
            if (!misal) begin
                mem_m[i] = data;
                if (adr == 32'd84) begin done_m = 1; dv_m = data; end
            end
        end else rd_m = misal ? 32'd0 : mem_m[i];
        if (misal || (wr && rd)) err_m = 1;
        if (use_model) begin e_rd = rd_m; e_dv = dv_m; e_done = done_m; e_err = err_m; end
        chk({tag, " stall_cycles"}, 32'(n), 32'(WC));
        chk({tag, " readdata"}, readdata, e_rd);
        chk({tag, " done"}, 32'(done), 32'(e_done));
        chk({tag, " done_value"}, done_value, e_dv);
        chk({tag, " err"}, 32'(err), 32'(e_err));
        @(posedge clk); #1;
        memwrite = 0; memread = 0;
    endtask

    task automatic model_reset();
        rd_m = '0; dv_m = '0; done_m = 0; err_m = 0;
    endtask

    task automatic check_after_reset(input string tag);
        @(negedge clk);
        chk({tag, " stall"}, 32'(stall), 32'd0);
        chk({tag, " done"}, 32'(done), 32'd0);
        chk({tag, " err"}, 32'(err), 32'd0);
        chk({tag, " readdata"}, readdata, 32'd0);
        chk({tag, " done_value"}, done_value, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        tbl[0]  = '{1, 0, 80,  32'hDEADBEEF, 32'h0,        32'd0, 0, 0};
        tbl[1]  = '{0, 1, 80,  32'h0,        32'hDEADBEEF, 32'd0, 0, 0};
        tbl[2]  = '{1, 0, 84,  32'd7,        32'hDEADBEEF, 32'd7, 1, 0};
        tbl[3]  = '{1, 0, 84,  32'd9,        32'hDEADBEEF, 32'd9, 1, 0};
        tbl[4]  = '{0, 1, 84,  32'h0,        32'd9,        32'd9, 1, 0};
        tbl[5]  = '{1, 0, 260, 32'h11,       32'd9,        32'd9, 1, 0};
        tbl[6]  = '{0, 1, 4,   32'h0,        32'h11,       32'd9, 1, 0};
        tbl[7]  = '{1, 0, 82,  32'hFFFF,     32'h11,       32'd9, 1, 1};
        tbl[8]  = '{0, 1, 80,  32'h0,        32'hDEADBEEF, 32'd9, 1, 1};
        tbl[9]  = '{0, 1, 82,  32'h0,        32'h0,        32'd9, 1, 1};
        tbl[10] = '{1, 1, 88,  32'd5,        32'h0,        32'd9, 1, 1};
        tbl[11] = '{0, 1, 88,  32'h0,        32'd5,        32'd9, 1, 1};
        tbl[12] = '{1, 0, 8,   32'h77,       32'd5,        32'd9, 1, 1};

        // reset held with a store pending on the bus
        memwrite = 1; dataadr = 32'd8; writedata = 32'h55;
        repeat (3) @(posedge clk);
        #1 reset_n = 1; memwrite = 0;
        check_after_reset("por");

        foreach (tbl[k])
            access(tbl[k].wr, tbl[k].rd, tbl[k].adr, tbl[k].data, 0,
                   tbl[k].e_rd, tbl[k].e_dv, tbl[k].e_done, tbl[k].e_err, $sformatf("vec%0d", k));

        // reset during the wait state of a store must discard it
        memwrite = 1; dataadr = 32'd8; writedata = 32'hAA;
        @(posedge clk);
        @(negedge clk);
        chk("mid wait stall", 32'(stall), 32'd1);
        reset_n = 0; memwrite = 0;
        @(posedge clk); #1 reset_n = 1;
        model_reset();
        check_after_reset("mid");
        access(0, 1, 8, 0, 1, 0, 0, 0, 0, "mid load8");

        // reset held with a store on the bus must not write
        memwrite = 1; dataadr = 32'd8; writedata = 32'h55; reset_n = 0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1; memwrite = 0;
        model_reset();
        check_after_reset("hold");
        access(0, 1, 8, 0, 1, 0, 0, 0, 0, "hold load8");

        for (int k = 0; k < DW; k++)
            access(1, 0, 32'(k * 4), $urandom, 1, 0, 0, 0, 0, "fill");
        for (int k = 0; k < 150; k++) begin
            int r = $urandom_range(0, 9);
            bit w = (r < 4) || (r == 9);
            bit rr = !w || (r == 9);
            logic [31:0] a = 32'($urandom_range(0, 127)) * 4;
            if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
            else if ($urandom_range(0, 9) == 0) a = 32'd84;
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            access(w, rr, a, $urandom, 1, 0, 0, 0, 0, $sformatf("rnd%0d", k));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
